clock_monitor: RTL and testbench
================================

// Module: clock_monitor
// PURPOSE
//  Receiving end of the divided clocks from clock_generator (clk_1/3/6/100).
//  Synchronises one slow divided clock into the clk domain and detects its
//  rising edges. Measures the period in clk cycles and reports each completed
//  period with a one-cycle valid strobe. Flags a stalled clock (timeout) and an
//  implausibly fast or glitching clock (too_fast). Used to self-check the
//  divider chain and to feed measured rates to display/LCD logic.
// PARAMETERS
//  CNT_W       26          period counter width; covers 1 Hz at 40 MHz (40e6 cycles)
//  SYNC_STAGES 2           synchroniser flops on clk_in, >=2
//  TIMEOUT     50_000_000  cycles with no rising edge before timeout asserts
//  MIN_PERIOD  4           shortest accepted period in cycles; shorter sets too_fast
// PORTS
//  clk          in   1      system clock (40 MHz board clock)
//  rst          in   1      asynchronous, active-high reset
//  clk_in       in   1      divided clock under test; asynchronous to clk
//  clear        in   1      synchronous: drop the measurement in progress, go to IDLE
//  period       out  CNT_W  last valid measured period in clk cycles
//  period_valid out  1      one-cycle pulse when period updates
//  timeout      out  1      level: no rising edge for TIMEOUT cycles
//  too_fast     out  1      one-cycle pulse: edge arrived with count < MIN_PERIOD
//  locked       out  1      level: at least one valid period since IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; count=0; synchroniser flops 0.
//  rise: one-cycle pulse SYNC_STAGES+1 clk cycles after clk_in rises.
//   It is formed from the last sync stage and one extra edge flop.
//  FSM states:
//   IDLE    : wait for rise. On rise: count<=1, ->MEASURE. No valid strobe.
//   MEASURE : count increments by 1 each cycle. On rise:
//             - count >= MIN_PERIOD: period<=count, period_valid=1 next cycle,
//               locked<=1, count<=1.
//             - count <  MIN_PERIOD: too_fast=1; period, locked and
//               period_valid unchanged; count<=1.
//             With no rise and count==TIMEOUT-1: ->STALL, timeout<=1,
//             locked<=0.
//   STALL   : count holds at TIMEOUT-1. On rise: timeout<=0, count<=1,
//             ->MEASURE. A partial period never produces period_valid.
//  Period definition: for rise pulses P clk cycles apart, period==P.
//  Counter never wraps or saturates past TIMEOUT-1. CNT_W is sized so that
//   TIMEOUT-1 fits; a parameter violating this is an elaboration error.
//  clear has priority over rise in every state. It takes effect next cycle:
//   ->IDLE, count=0, timeout=0, locked=0. period keeps its last value.
//  Rise in the same cycle as the timeout condition: the rise wins; it is
//   handled as a MEASURE edge and the state stays MEASURE.
//  rst mid-operation returns every register to its reset value immediately.
//   The first rise after reset is treated as an IDLE edge.
//  period_valid and too_fast never assert in the same cycle.
// STRUCTURE
//  global.v: add CLK_MON_CNT_W, CLK_MON_TIMEOUT and the state encodings
//   CLK_MON_IDLE=2'd0, CLK_MON_MEASURE=2'd1, CLK_MON_STALL=2'd2.
//  Sub-module sync_edge_detect (params SYNC_STAGES): async in -> rise pulse.
//   It is reusable for push-buttons and other slow inputs.
//  Top level holds the FSM, the period counter and the output registers.
//   The design uses a two-process style: next-state logic plus flops.
// TESTING  (bench: clk 40 MHz, TIMEOUT=100, MIN_PERIOD=4, CNT_W=8)
//  1 clk_in square wave with 20-cycle period -> first rise gives no valid;
//    then period_valid every 20 cycles with period==20; locked=1 after the
//    2nd rise.
//  2 clk_in held low after lock -> timeout=1 exactly 100 cycles after the
//    last rise, locked=0. Next two rises: timeout=0, then period_valid with
//    the true period.
//  3 Glitch: rises 2 cycles apart while in MEASURE -> too_fast pulse;
//    period unchanged; next rise 20 cycles later gives period==20, not 22.
//  4 rst asserted mid-measurement, then released -> all outputs 0
//    immediately; first rise after release gives no valid.
//  5 clear and rise in the same cycle -> state IDLE, no period_valid, no
//    too_fast; period keeps its old value.
//  6 Rise exactly on cycle TIMEOUT-1 -> period_valid with period==99 and
//    timeout stays 0.

Source files
------------

// File: rtl/clock_monitor_pkg.sv
// Shared constants, state encoding and elaboration helpers for the divided-clock monitor.
// Defaults target a 40 MHz system clock watching dividers down to 1 Hz.

package clock_monitor_pkg;

   localparam int unsigned CLK_MON_CNT_W       = 26;
   localparam int unsigned CLK_MON_TIMEOUT     = 50_000_000;
   localparam int unsigned CLK_MON_SYNC_STAGES = 2;
   localparam int unsigned CLK_MON_MIN_PERIOD  = 4;

   typedef enum logic [1:0] {
      CLK_MON_IDLE    = 2'd0,
      CLK_MON_MEASURE = 2'd1,
      CLK_MON_STALL   = 2'd2
   } clk_mon_state_e;

   // True when the largest count the monitor can hold (timeout - 1) fits in cnt_w bits.
   function automatic bit timeout_fits(input int unsigned cnt_w, input int unsigned timeout);
      return (64'(timeout) - 64'd1) < (64'd1 << cnt_w);
   endfunction

endpackage

// File: rtl/clock_monitor_sync_edge_detect.sv
// Brings an asynchronous slow input into the clk domain and flags its rising edges.
// Reusable for push-buttons and other slow asynchronous inputs.

module clock_monitor_sync_edge_detect #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise_c
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;

   generate
      if (SYNC_STAGES < 2) begin : g_bad_stages
         $error("clock_monitor_sync_edge_detect: SYNC_STAGES must be at least 2");
      end
   endgenerate

   // Synchroniser chain followed by one edge flop holding the previous synchronised value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         edge_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise_c = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/clock_monitor.sv
// Measures the period of a slow divided clock in clk cycles, reporting each
// completed period and flagging stalled (timeout) or too-fast/glitching input.

module clock_monitor
   import clock_monitor_pkg::*;
#(
   parameter int unsigned CNT_W       = CLK_MON_CNT_W,
   parameter int unsigned SYNC_STAGES = CLK_MON_SYNC_STAGES,
   parameter int unsigned TIMEOUT     = CLK_MON_TIMEOUT,
   parameter int unsigned MIN_PERIOD  = CLK_MON_MIN_PERIOD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_in,
   input  logic             clear,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             timeout,
   output logic             too_fast,
   output logic             locked
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PERIOD);

   generate
      if (!timeout_fits(CNT_W, TIMEOUT)) begin : g_bad_cnt_w
         $error("clock_monitor: CNT_W too narrow to hold TIMEOUT-1");
      end
   endgenerate

   logic             rise_c;
   clk_mon_state_e   state,        state_n;
   logic [CNT_W-1:0] count,        count_n;
   logic [CNT_W-1:0] period_n;
   logic             period_valid_n;
   logic             timeout_n;
   logic             too_fast_n;
   logic             locked_n;

   clock_monitor_sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk      (clk),
      .rst      (rst),
      .async_in (clk_in),
      .rise_c   (rise_c)
   );

   // Next-state and next-output logic; clear outranks any edge, and an edge outranks timeout.
   always_comb begin
      state_n        = state;
      count_n        = count;
      period_n       = period;
      period_valid_n = 1'b0;
      too_fast_n     = 1'b0;
      timeout_n      = timeout;
      locked_n       = locked;

      if (clear) begin
         state_n   = CLK_MON_IDLE;
         count_n   = '0;
         timeout_n = 1'b0;
         locked_n  = 1'b0;
      end else begin
         unique case (state)
            CLK_MON_IDLE: begin
               if (rise_c) begin
                  count_n = CNT_ONE;
                  state_n = CLK_MON_MEASURE;
               end
            end

            CLK_MON_MEASURE: begin
               if (rise_c) begin
                  count_n = CNT_ONE;
                  if (count >= CNT_MIN) begin
                     period_n       = count;
                     period_valid_n = 1'b1;
                     locked_n       = 1'b1;
                  end else begin
                     too_fast_n = 1'b1;
                  end
               end else if (count == CNT_MAX) begin
                  state_n   = CLK_MON_STALL;
                  timeout_n = 1'b1;
                  locked_n  = 1'b0;
               end else begin
                  count_n = count + CNT_ONE;
               end
            end

            CLK_MON_STALL: begin
               // Count stays parked at TIMEOUT-1; the partial period is discarded.
               if (rise_c) begin
                  timeout_n = 1'b0;
                  count_n   = CNT_ONE;
                  state_n   = CLK_MON_MEASURE;
               end
            end

            default: begin
               state_n = CLK_MON_IDLE;
               count_n = '0;
            end
         endcase
      end
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= CLK_MON_IDLE;
         count        <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         timeout      <= 1'b0;
         too_fast     <= 1'b0;
         locked       <= 1'b0;
      end else begin
         state        <= state_n;
         count        <= count_n;
         period       <= period_n;
         period_valid <= period_valid_n;
         timeout      <= timeout_n;
         too_fast     <= too_fast_n;
         locked       <= locked_n;
      end
   end

endmodule

// File: tb/tb_clock_monitor.sv
// Scoreboard bench for clock_monitor: stimulus queues expected strobes, a monitor
// pops and compares them whenever period_valid or too_fast is seen.

module tb_clock_monitor;

   localparam int unsigned CNT_W       = 8;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned TIMEOUT     = 100;
   localparam int unsigned MIN_PERIOD  = 4;

   localparam int EV_NONE  = 0;
   localparam int EV_VALID = 1;
   localparam int EV_FAST  = 2;

   logic             clk    = 1'b0;
   logic             rst    = 1'b1;
   logic             clk_in = 1'b0;
   logic             clear  = 1'b0;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             timeout;
   logic             too_fast;
   logic             locked;

   typedef struct {
      int kind;
      int per;
      int lock;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   clock_monitor #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT     (TIMEOUT),
      .MIN_PERIOD  (MIN_PERIOD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .clk_in       (clk_in),
      .clear        (clear),
      .period       (period),
      .period_valid (period_valid),
      .timeout      (timeout),
      .too_fast     (too_fast),
      .locked       (locked)
   );

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One rising edge on clk_in; the next call starts exactly gap clk cycles later.
   task automatic edge_in(input int gap);
      clk_in = 1'b1;
      @(negedge clk);
      clk_in = 1'b0;
      repeat (gap - 1) @(negedge clk);
   endtask

   // Rising edge whose handling should produce the given strobe (or none).
   task automatic rise(input int gap, input int kind, input int per);
      exp_t e;
      if (kind != EV_NONE) begin
         e.kind = kind;
         e.per  = per;
         e.lock = 1;
         exp_q.push_back(e);
      end
      edge_in(gap);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_period"},       int'(period),       0);
      check({tag, "_period_valid"}, int'(period_valid), 0);
      check({tag, "_timeout"},      int'(timeout),      0);
      check({tag, "_too_fast"},     int'(too_fast),     0);
      check({tag, "_locked"},       int'(locked),       0);
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && (period_valid || too_fast)) begin
         check("strobe_exclusive", int'(period_valid && too_fast), 0);
         check("strobe_expected", int'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("strobe_kind",   period_valid ? EV_VALID : EV_FAST, mon_e.kind);
            check("strobe_period", int'(period), mon_e.per);
            check("strobe_locked", int'(locked), mon_e.lock);
         end
      end
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // 1: 20-cycle square wave; first edge only arms the measurement
      rise(20, EV_NONE, 0);
      check("t1_locked_after_first", int'(locked), 0);
      rise(20, EV_VALID, 20);
      check("t1_locked_after_second", int'(locked), 1);
      for (int i = 0; i < 4; i++) rise(20, EV_VALID, 20);

      // 2: clk_in stops after lock; timeout exactly 100 cycles after the last edge
      exp_q.push_back('{kind: EV_VALID, per: 20, lock: 1});
      clk_in = 1'b1;
      @(negedge clk);
      clk_in = 1'b0;
      repeat (100) @(negedge clk);
      check("t2_timeout_early", int'(timeout), 0);
      @(negedge clk);
      check("t2_timeout_set", int'(timeout), 1);
      check("t2_locked_dropped", int'(locked), 0);
      rise(20, EV_NONE, 0);
      check("t2_timeout_cleared", int'(timeout), 0);
      rise(30, EV_VALID, 20);

      // 3: glitch two cycles after an edge; period keeps 30, count restarts
      rise(2, EV_VALID, 30);
      rise(20, EV_FAST, 30);
      rise(20, EV_VALID, 20);
      check("t3_period_after_glitch", int'(period), 20);
      check("t3_queue_drained", exp_q.size(), 0);

      // 4: asynchronous reset mid-measurement
      rst = 1'b1;
      #1;
      check_all_zero("t4_rst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rise(20, EV_NONE, 0);
      check("t4_locked_after_first", int'(locked), 0);
      rise(25, EV_VALID, 20);

      // 5: clear in the same cycle as a rise; old period retained, back to IDLE
      clk_in = 1'b1;
      @(negedge clk);
      clk_in = 1'b0;
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("t5_locked_cleared", int'(locked), 0);
      check("t5_period_kept", int'(period), 20);
      check("t5_timeout", int'(timeout), 0);
      repeat (17) @(negedge clk);
      rise(20, EV_NONE, 0);

      // 6: edge lands on count == TIMEOUT-1; the edge wins over timeout
      rise(99, EV_VALID, 20);
      rise(20, EV_VALID, 99);
      check("t6_timeout_stays_low", int'(timeout), 0);
      check("t6_period", int'(period), 99);
      check("t6_locked", int'(locked), 1);

      repeat (10) @(negedge clk);
      check("final_queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
